// File: rtl/mult_cpa_pipe.sv
// Final carry-propagate stage of the 16x16 multiplier: two-stage split adder with valid/ready.
// Optional carry-out flag port ovf when MULT_CPA_OVF_EN is defined.
module mult_cpa_pipe #(
  parameter int WIDTH = 32,
  parameter int SPLIT = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_sum,
  input  logic [WIDTH-1:0] in_carry,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH-1:0] prod,
  output logic             out_valid,
  input  logic             out_ready
`ifdef MULT_CPA_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int HW = WIDTH - SPLIT;

  logic            s1_valid;
  logic [SPLIT:0]  s1_lo;
  logic [HW-1:0]   s1_sum_hi;
  logic [HW-1:0]   s1_carry_hi;
  logic            s2_ready;

`ifdef MULT_CPA_OVF_EN
  logic [HW:0]     hi;
  assign hi = {1'b0, s1_sum_hi} + {1'b0, s1_carry_hi} + (HW+1)'(s1_lo[SPLIT]);
`else
  logic [HW-1:0]   hi;
  assign hi = s1_sum_hi + s1_carry_hi + HW'(s1_lo[SPLIT]);
`endif

  // Each stage accepts when it is empty or its contents move on in the same cycle.
  assign s2_ready = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_ready;

  // Stage 1 resolves the low segment and parks the upper operand bits for stage 2.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid    <= 1'b0;
      s1_lo       <= '0;
      s1_sum_hi   <= '0;
      s1_carry_hi <= '0;
    end else begin
      if (in_ready) s1_valid <= in_valid;
      if (in_valid && in_ready) begin
        s1_lo       <= {1'b0, in_sum[SPLIT-1:0]} + {1'b0, in_carry[SPLIT-1:0]};
        s1_sum_hi   <= in_sum[WIDTH-1:SPLIT];
        s1_carry_hi <= in_carry[WIDTH-1:SPLIT];
      end
    end
  end

  // Stage 2 folds in the low-segment carry and holds the result until downstream takes it.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      prod      <= '0;
`ifdef MULT_CPA_OVF_EN
      ovf       <= 1'b0;
`endif
    end else begin
      if (s2_ready) out_valid <= s1_valid;
      if (s1_valid && s2_ready) begin
        prod <= {hi[HW-1:0], s1_lo[SPLIT-1:0]};
`ifdef MULT_CPA_OVF_EN
        ovf  <= hi[HW];
`endif
      end
    end
  end

endmodule

// File: tb/tb_mult_cpa_pipe.sv
// Self-checking bench for mult_cpa_pipe: directed cases plus randomized throttled traffic
// scored against a queue of plain (sum+carry) results.
module tb_mult_cpa_pipe;
  localparam int WIDTH = 32;
  parameter int SPLIT = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_sum, in_carry;
  logic        in_valid, in_ready;
  logic [31:0] prod;
  logic        out_valid, out_ready;
`ifdef MULT_CPA_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  mult_cpa_pipe #(.WIDTH(WIDTH), .SPLIT(SPLIT)) dut (
    .clk(clk), .rst(rst),
    .in_sum(in_sum), .in_carry(in_carry), .in_valid(in_valid), .in_ready(in_ready),
    .prod(prod), .out_valid(out_valid), .out_ready(out_ready)
`ifdef MULT_CPA_OVF_EN
    , .ovf(ovf)
`endif
  );

  int          total = 0;
  int          bad = 0;
  logic [32:0] exp_q[$];
  logic        acc_in = 1'b0;
  logic        acc_out = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_prod = '0;
  logic        prev_ovf = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("[TB] FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  function automatic logic get_ovf();
`ifdef MULT_CPA_OVF_EN
    return ovf;
`else
    return 1'b0;
`endif
  endfunction

  task automatic applyStimulus(input logic v, input logic [31:0] s, input logic [31:0] c,
                               input logic ordy);
    in_valid  = v;
    in_sum    = s;
    in_carry  = c;
    out_ready = ordy;
  endtask

  // Compares the DUT against the model once per cycle, mid-cycle, before the edge commits.
  task automatic checkOutput();
    logic [32:0] e;
    if (rst) begin
      acc_in = 1'b0;
      acc_out = 1'b0;
      prev_stall = 1'b0;
      return;
    end
    if (prev_stall) begin
      check("stall_valid", 64'(out_valid), 64'd1);
      check("stall_prod", 64'(prod), 64'(prev_prod));
`ifdef MULT_CPA_OVF_EN
      check("stall_ovf", 64'(ovf), 64'(prev_ovf));
`endif
    end
    check("in_ready", 64'(in_ready), 64'((exp_q.size() < 2) || out_ready));
    acc_in  = in_valid && in_ready;
    acc_out = out_valid && out_ready;
    if (acc_out) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("[TB] FAIL unexpected_out actual=0x%0h required=none", prod);
      end else begin
        e = exp_q.pop_front();
        check("prod", 64'(prod), 64'(e[31:0]));
`ifdef MULT_CPA_OVF_EN
        check("ovf", 64'(ovf), 64'(e[32]));
`endif
      end
    end
    prev_stall = out_valid && !out_ready;
    prev_prod  = prod;
    prev_ovf   = get_ovf();
  endtask

  task automatic step();
    logic [32:0] full;
    logic        r;
    #1;
    checkOutput();
    full = {1'b0, in_sum} + {1'b0, in_carry};
    r = rst;
    @(posedge clk);
    if (r) exp_q.delete();
    else if (acc_in) exp_q.push_back(full);
    @(negedge clk);
  endtask

  initial begin
    logic [31:0] t3_s[4];
    logic [31:0] t3_c[4];
    logic [31:0] t3_e[4];
    logic [31:0] t4_s[3];
    logic [31:0] t4_c[3];
    int k, outs, n, cyc;

    t3_s = '{32'h00000001, 32'h00000100, 32'hFFFF0000, 32'hDEADBEEF};
    t3_c = '{32'h00000002, 32'h00000200, 32'h00010000, 32'h11111111};
    t3_e = '{32'h00000003, 32'h00000300, 32'h00000000, 32'hEFBED000};
    t4_s = '{32'h00000010, 32'h00001000, 32'h7FFFFFFF};
    t4_c = '{32'h00000020, 32'h00000001, 32'h00000001};

    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_prod", 64'(prod), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_ovf", 64'(get_ovf()), 64'd0);

    // Low-segment carry must cross into the upper segment.
    applyStimulus(1'b1, 32'h0000FFFF, 32'h00000001, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    #1;
    check("t1_valid", 64'(out_valid), 64'd1);
    check("t1_prod", 64'(prod), 64'h00010000);
    step();

    applyStimulus(1'b1, 32'hFFFFFFFF, 32'h00000001, 1'b1);
    step();
    applyStimulus(1'b1, 32'h12345678, 32'h00000000, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check("t2a_prod", 64'(prod), 64'h0);
`ifdef MULT_CPA_OVF_EN
    check("t2a_ovf", 64'(ovf), 64'd1);
`endif
    step();
    #1;
    check("t2b_prod", 64'(prod), 64'h12345678);
`ifdef MULT_CPA_OVF_EN
    check("t2b_ovf", 64'(ovf), 64'd0);
`endif
    step();

    for (int i = 0; i < 6; i++) begin
      if (i < 4) applyStimulus(1'b1, t3_s[i], t3_c[i], 1'b1);
      else applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      #1;
      if (i < 4) check("t3_in_ready", 64'(in_ready), 64'd1);
      step();
      #1;
      check("t3_out_valid", 64'(out_valid), 64'((i >= 1) && (i <= 4)));
      if (i >= 1 && i <= 4) check("t3_prod", 64'(prod), 64'(t3_e[i-1]));
    end

    // Back-pressure: only two items fit, the first one must sit still on prod.
    k = 0;
    for (int i = 0; i < 6; i++) begin
      applyStimulus(1'b1, t4_s[k], t4_c[k], 1'b0);
      step();
      if (acc_in) k++;
    end
    #1;
    check("t4_accepted", 64'(k), 64'd2);
    check("t4_in_ready", 64'(in_ready), 64'd0);
    check("t4_stall_prod", 64'(prod), 64'h00000030);
    outs = 0;
    for (int i = 0; i < 10; i++) begin
      if (k < 3) applyStimulus(1'b1, t4_s[k], t4_c[k], 1'b1);
      else applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      step();
      if (acc_in) k++;
      if (acc_out) outs++;
    end
    check("t4_emitted", 64'(outs), 64'd3);

    applyStimulus(1'b1, 32'h11110000, 32'h00002222, 1'b0);
    step();
    applyStimulus(1'b1, 32'h33330000, 32'h00004444, 1'b0);
    step();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    step();
    rst = 1'b0;
    #1;
    check("t5_out_valid", 64'(out_valid), 64'd0);
    check("t5_in_ready", 64'(in_ready), 64'd1);
    applyStimulus(1'b1, 32'h00ABCDEF, 32'h00000011, 1'b1);
    step();
    applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
    #1;
    check("t5_latency1_valid", 64'(out_valid), 64'd0);
    step();
    #1;
    check("t5_valid", 64'(out_valid), 64'd1);
    check("t5_prod", 64'(prod), 64'h00ABCE00);
    step();

    n = 0;
    cyc = 0;
    while (n < 10000 && cyc < 60000) begin
      logic [31:0] rs;
      rs = ($urandom_range(0, 15) == 0) ? 32'hFFFFFFFF : $urandom;
      applyStimulus($urandom_range(0, 3) != 0, rs, $urandom, $urandom_range(0, 3) != 0);
      step();
      if (acc_in) n++;
      cyc++;
    end
    check("t6_accepted", 64'(n), 64'd10000);
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) begin
      applyStimulus(1'b0, 32'h0, 32'h0, 1'b1);
      step();
    end
    check("t6_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
